// File: rtl/multi_zone_motion_timer_pkg.sv
// Shared types and constants for the multi-zone motion timer.
package motion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REARM  = 2'd2
  } state_t;

  localparam logic MODE_RETRIG  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Width needed to count 0..cycles inclusive.
  function automatic int unsigned db_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/multi_zone_motion_timer_if.sv
// Sensor-side inputs and controller-side outputs of the motion timer.
interface multi_zone_motion_timer_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned HOLD_W   = 32
);
  logic [CHANNELS-1:0] motion;
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] mode;
  logic [HOLD_W-1:0]   hold_cycles;
  logic [CHANNELS-1:0] active;
  logic                any_active;
  logic [CHANNELS-1:0] expired;

  modport master (
    output motion, enable, mode, hold_cycles,
    input  active, any_active, expired
  );

  modport slave (
    input  motion, enable, mode, hold_cycles,
    output active, any_active, expired
  );
endinterface

// File: rtl/multi_zone_motion_timer_zone.sv
// One zone: synchroniser, debouncer and hold FSM driving active/expired.
module motion_zone
  import motion_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_W          = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              motion,
  input  logic              enable,
  input  logic              mode,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              active,
  output logic              expired
);

  localparam int unsigned     DB_W    = db_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [DB_W-1:0]        db_cnt;
  logic                   db;

  state_t            state, state_next;
  logic [HOLD_W-1:0] cnt, cnt_next;
  logic [HOLD_W-1:0] hold_load;
  logic              expire_next;

  assign s         = sync[SYNC_STAGES-1];
  assign hold_load = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;

  // db flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '0;
      db_cnt <= '0;
      db     <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], motion};
      if (s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        db     <= s;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      expired <= expire_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    expire_next = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (db) begin
            state_next = ST_ACTIVE;
            cnt_next   = hold_load;
          end
        end
        ST_ACTIVE: begin
          if (mode == MODE_ONESHOT) begin
            if (cnt == HOLD_W'(1)) begin
              state_next  = ST_REARM;
              cnt_next    = '0;
              expire_next = 1'b1;
            end else begin
              cnt_next = cnt - HOLD_W'(1);
            end
          end else if (db) begin
            cnt_next = hold_load;
          end else if (cnt == HOLD_W'(1)) begin
            state_next  = ST_IDLE;
            cnt_next    = '0;
            expire_next = 1'b1;
          end else begin
            cnt_next = cnt - HOLD_W'(1);
          end
        end
        ST_REARM: begin
          if (!db) state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    active = (state == ST_ACTIVE);
  end

endmodule

// File: rtl/multi_zone_motion_timer.sv
// CHANNELS independent motion zones plus a registered any-zone-active flag.
module multi_zone_motion_timer
  import motion_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_W          = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  multi_zone_motion_timer_if.slave bus
);

  logic [CHANNELS-1:0] active;
  logic [CHANNELS-1:0] expired;
  logic                any_active;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_zone
    motion_zone #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_W          (HOLD_W)
    ) u_zone (
      .clk         (clk),
      .reset_n     (reset_n),
      .motion      (bus.motion[i]),
      .enable      (bus.enable[i]),
      .mode        (bus.mode[i]),
      .hold_cycles (bus.hold_cycles),
      .active      (active[i]),
      .expired     (expired[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_active <= 1'b0;
    else          any_active <= |active;
  end

  assign bus.active     = active;
  assign bus.expired    = expired;
  assign bus.any_active = any_active;

endmodule

// File: doc/multi_zone_motion_timer.md
# multi_zone_motion_timer

Multi-channel successor to the single-sensor motion timer. Each of CHANNELS zones takes a raw PIR/motion input and passes it through a synchroniser and a debouncer. A per-zone FSM then holds that zone's `active` output for a runtime-programmable number of cycles after motion ends, in either retrigger or one-shot mode. The block sits between the sensor pins and the lighting/alarm controller, which consumes `active`, `any_active` and the `expired` pulses.

## Interface
- CHANNELS, 4 — number of independent zones (1..16)
- SYNC_STAGES, 2 — flip-flop synchroniser depth per input (≥2)
- DEBOUNCE_CYCLES, 4 — consecutive equal synced samples required to change the debounced level (≥1)
- HOLD_W, 32 — width of the hold counter and of `hold_cycles`

- clk  in  1  system clock
- reset_n  in  1  reset; one clock, asynchronous, active-low
- motion  in  CHANNELS  raw asynchronous sensor inputs, bit i = zone i
- enable  in  CHANNELS  per-zone enable; low forces the zone to IDLE
- mode  in  CHANNELS  per-zone mode; 0 = retrigger, 1 = one-shot
- hold_cycles  in  HOLD_W  hold duration in clk cycles, shared by all zones, sampled at each load
- active  out  CHANNELS  zone on
- any_active  out  1  OR-reduction of `active`, registered
- expired  out  CHANNELS  one-cycle pulse when a zone times out

## Operation
- **Per-zone front end**
  - SYNC_STAGES flops produce `s`.
  - Debounce counter tracks how many samples `s` has differed from debounced level `db`.
  - `db` flips once `s` has differed for DEBOUNCE_CYCLES consecutive samples.
  - Any sample where `s == db` clears the counter. Reset value of `db` is 0.
- **FSM states:** IDLE, ACTIVE, REARM. Reset state is IDLE.
- **IDLE**
  - `db`=1 and `enable`=1 → ACTIVE, and load cnt = max(hold_cycles, 1).
- **ACTIVE, retrigger mode**
  - While `db`=1, reload cnt every cycle.
  - While `db`=0, decrement cnt.
  - When `db`=0 and cnt==1 → IDLE and pulse `expired`.
- **ACTIVE, one-shot mode**
  - `db` is ignored; cnt decrements every cycle from the load.
  - When cnt==1 → REARM and pulse `expired`.
- **REARM:** `db`=0 → IDLE. The zone cannot retrigger until motion has been released.
- **Outputs:**
  - `active`=1 exactly while state is ACTIVE.
  - `expired` is a registered one-cycle pulse on the ACTIVE→IDLE or ACTIVE→REARM transition.
- **Enable:** `enable`=0 in any state → IDLE next cycle, cnt cleared, no `expired` pulse. Front end keeps running.
- **Mode change:** `mode` is sampled every cycle. A change during ACTIVE applies from the next cycle and does not reload cnt.
- **Simultaneous events**
  - `enable` fall wins over expiry: no pulse.
  - In retrigger mode, `db` rising on the cycle cnt==1 reloads, with no expiry.
- **Arithmetic:**
  - cnt is HOLD_W bits, unsigned.
  - `hold_cycles`=0 is treated as 1.
  - cnt never wraps: decrement stops at 1 by transition.
- **Reset mid-operation:** all state, counters, `db`, sync flops, `active`, `any_active` and `expired` go to 0 immediately (asynchronous); IDLE on release.

## Timing
- Raw `motion` rise (stable) to `active` rise: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles. With defaults this is 7.
- `any_active` lags `active` by 1 cycle.
- **Retrigger mode:** `active` stays high for exactly hold_cycles cycles after the cycle `db` falls. `db` falls SYNC_STAGES + DEBOUNCE_CYCLES cycles after the raw fall.
- **One-shot mode:** `active` high for exactly max(hold_cycles, 1) cycles.
- `expired` is high on the same cycle `active` first reads 0.
- Glitches shorter than DEBOUNCE_CYCLES synced samples produce no state change.

## Structure
- **Package `motion_pkg`:**
  - state encoding ST_IDLE/ST_ACTIVE/ST_REARM
  - mode constants MODE_RETRIG=0 / MODE_ONESHOT=1
  - helper for the debounce counter width, clog2(DEBOUNCE_CYCLES+1)
- **Sub-module `motion_zone`:** one zone (synchroniser, debouncer, FSM, hold counter), outputs `active`/`expired`.
- **Top:** generate loop of CHANNELS `motion_zone` instances, plus the registered OR for `any_active`.

## Test plan
- **Basic retrigger:** defaults, hold_cycles=10. Zone 0 motion high 20 cycles then low → `active[0]` rises 7 cycles after the raw rise, falls 10 cycles after `db` falls; `expired[0]` is a single 1-cycle pulse; `any_active` follows 1 cycle late.
- **Glitch rejection:** 3-cycle motion pulse on zone 1 → `active[1]` and `expired[1]` stay 0 throughout.
- **One-shot:** mode[2]=1, hold_cycles=5, motion held high 50 cycles → `active[2]` high exactly 5 cycles, `expired[2]` pulses once, no retrigger until motion has been low ≥6 cycles; a second motion then re-activates.
- **Enable and retrigger boundary:**
  - `enable[3]` dropped mid-hold → `active[3]`=0 next cycle, `expired[3]`=0.
  - Separately, motion re-debounced on the cycle cnt==1 → zone stays active, no pulse.
- **hold_cycles=0 and all zones simultaneous:** all 4 zones triggered on the same edge → all `active` rise together, each lasts 1 cycle after release, 4 `expired` pulses on the same cycle.
- **Async reset mid-hold:** `reset_n` low between clock edges while zones are active → `active`, `any_active`, `expired` read 0 before the next edge; after release, a fresh trigger needs the full 7-cycle latency.
